dds_hop_sched: RTL



---
 rtl/dds_hop_sched.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dds_hop_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dds_hop_sched
// Purpose  : Table-driven frequency-hop scheduler feeding four ad9914_ctrl
//            instances. Steps through {mask, FTW} entries. For each entry it
//            loads the lower/upper limit FTWs, runs the update/busy handshake
//            with every selected channel, then holds for a dwell time.
// Ports    : clk/rst        - clock, synchronous active-low reset
//            tbl_*          - table write port (idle only), entry count
//            dwell          - hold cycles per entry (0 behaves as 1)
//            start/stop     - sequence control
//            running/done/err_timeout/cur_index/hop_strobe - status
//            ftw_l/ftw_u    - per-channel limit FTWs (32 bits per channel)
//            update/busy    - per-channel handshake with the controllers
// Config   : HOP_LOOP_EN - when defined, the table wraps forever until stop.
// Revision : 1.0 - initial release
// ============================================================================
module dds_hop_sched #(
  parameter int DEPTH_LOG2   = 4,
  parameter int DWELL_W      = 32,
  parameter int BUSY_TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tbl_we,
  input  logic [DEPTH_LOG2-1:0] tbl_addr,
  input  logic [35:0]           tbl_wdata,
  input  logic [DEPTH_LOG2:0]   tbl_len,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  start,
  input  logic                  stop,
  output logic                  running,
  output logic                  done,
  output logic                  err_timeout,
  output logic [DEPTH_LOG2-1:0] cur_index,
  output logic                  hop_strobe,
  output logic [127:0]          ftw_l,
  output logic [127:0]          ftw_u,
  output logic [3:0]            update,
  input  logic [3:0]            busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0]     TO_LAST = TO_W'(BUSY_TIMEOUT - 1);
  localparam logic [DEPTH_LOG2:0] DEPTH_V = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_RD  = 3'd1,
    S_LOAD_CAP = 3'd2,
    S_REQ      = 3'd3,
    S_WAIT     = 3'd4,
    S_DWELL    = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   index_q, index_d;
  logic [3:0]              mask_q, mask_d;
  logic [127:0]            ftw_l_q, ftw_l_d;
  logic [127:0]            ftw_u_q, ftw_u_d;
  logic [3:0]              update_q, update_d;
  logic                    stop_q, stop_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [DWELL_W-1:0]      dcnt_q, dcnt_d;
  logic                    done_q, done_d;
  logic                    hop_q, hop_d;
  logic                    err_q, err_d;

  logic [35:0]             mem_q [DEPTH];
  logic [35:0]             rdata_q;

  logic [DEPTH_LOG2:0]     len_c;
  logic [DWELL_W-1:0]      dwell_last;
  logic [DEPTH_LOG2:0]     idx_inc;

  // Table RAM: not reset, writes accepted only while idle, 1-cycle read.
  // The read address is the current index, so the word captured at the end
  // of LOAD_RD belongs to the entry being loaded.
  always_ff @(posedge clk) begin
    if (tbl_we && (state_q == S_IDLE)) begin
      mem_q[tbl_addr] <= tbl_wdata;
    end
    rdata_q <= mem_q[index_q];
  end

  always_comb begin
    len_c      = (tbl_len > DEPTH_V) ? DEPTH_V : tbl_len;
    dwell_last = (dwell == '0) ? '0 : dwell - 1'b1;
    idx_inc    = {1'b0, index_q} + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    mask_d   = mask_q;
    ftw_l_d  = ftw_l_q;
    ftw_u_d  = ftw_u_q;
    update_d = update_q;
    stop_d   = stop_q;
    to_cnt_d = to_cnt_q;
    dcnt_d   = dcnt_q;
    done_d   = 1'b0;
    hop_d    = 1'b0;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          if (len_c == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD_RD;
            index_d = '0;
            err_d   = 1'b0;
            stop_d  = 1'b0;
          end
        end
      end

      S_LOAD_RD: begin
        state_d = stop ? S_IDLE : S_LOAD_CAP;
      end

      S_LOAD_CAP: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          mask_d = rdata_q[35:32];
          for (int n = 0; n < 4; n++) begin
            if (rdata_q[32+n]) begin
              ftw_l_d[32*n +: 32] = rdata_q[31:0];
              ftw_u_d[32*n +: 32] = rdata_q[31:0] + 32'd1;
            end
          end
          if (rdata_q[35:32] == 4'b0) begin
            // Empty mask: no handshake, straight to the hold time.
            state_d = S_DWELL;
            dcnt_d  = '0;
          end else begin
            state_d  = S_REQ;
            update_d = rdata_q[35:32];
            to_cnt_d = '0;
          end
        end
      end

      S_REQ: begin
        if (to_cnt_q == TO_LAST) begin
          state_d  = S_IDLE;
          update_d = 4'b0;
          err_d    = 1'b1;
        end else begin
          // Each request bit drops independently once its busy is seen.
          update_d = update_q & ~busy;
          to_cnt_d = to_cnt_q + 1'b1;
          stop_d   = stop_q | stop;
          if (update_d == 4'b0) begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if ((busy & mask_q) == 4'b0) begin
          hop_d = 1'b1;
          if (stop_q || stop) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DWELL;
            dcnt_d  = '0;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = S_IDLE;
          update_d = 4'b0;
          err_d    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          stop_d   = stop_q | stop;
        end
      end

      S_DWELL: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (dcnt_q == dwell_last) begin
          if (idx_inc >= len_c) begin
`ifdef HOP_LOOP_EN
            index_d = '0;
            state_d = S_LOAD_RD;
`else
            done_d  = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            index_d = idx_inc[DEPTH_LOG2-1:0];
            state_d = S_LOAD_RD;
          end
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        update_d = 4'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      mask_q   <= '0;
      ftw_l_q  <= '0;
      ftw_u_q  <= '0;
      update_q <= '0;
      stop_q   <= 1'b0;
      to_cnt_q <= '0;
      dcnt_q   <= '0;
      done_q   <= 1'b0;
      hop_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      mask_q   <= mask_d;
      ftw_l_q  <= ftw_l_d;
      ftw_u_q  <= ftw_u_d;
      update_q <= update_d;
      stop_q   <= stop_d;
      to_cnt_q <= to_cnt_d;
      dcnt_q   <= dcnt_d;
      done_q   <= done_d;
      hop_q    <= hop_d;
      err_q    <= err_d;
    end
  end

  assign running     = (state_q != S_IDLE);
  assign done        = done_q;
  assign err_timeout = err_q;
  assign cur_index   = index_q;
  assign hop_strobe  = hop_q;
  assign ftw_l       = ftw_l_q;
  assign ftw_u       = ftw_u_q;
  // Requests are gated by reset so the controllers see them drop at once.
  assign update      = update_q & {4{rst}};

endmodule
`default_nettype wire
